// File: rtl/adc_rng_ctrl.sv
// ADC random-bit harvesting controller.
// Grants one ADC bit source at a time in round-robin order and streams its bits
// into a shared bit FIFO. Once a full word has been collected, the word is read
// back out of the FIFO and offered on a valid/ready output port. A source that
// goes quiet for too long has its partial word aborted, and the abort is counted.
module adc_rng_ctrl #(
  parameter int NUM_SRC   = 4,
  parameter int WORD_BITS = 10,
  parameter int STALL_MAX = 16,
  localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [NUM_SRC-1:0]   src_valid_i,
  input  logic [NUM_SRC-1:0]   src_bit_i,
  output logic [NUM_SRC-1:0]   src_ready_o,
  output logic                 fifo_enque_o,
  output logic                 fifo_deque_o,
  output logic                 fifo_data_o,
  input  logic [WORD_BITS-1:0] fifo_vector_i,
  input  logic                 fifo_full_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WORD_BITS-1:0] out_word_o,
  output logic [SRC_W-1:0]     out_src_o,
  output logic [7:0]           drop_cnt_o
);

  localparam int CNT_W   = $clog2(WORD_BITS + 1);
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    HOLD,
    FLUSH
  } state_e;

  state_e               state_q, state_d;
  logic [SRC_W-1:0]     grant_q, grant_d;
  logic [SRC_W-1:0]     last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic [WORD_BITS-1:0] out_word_q, out_word_d;
  logic [SRC_W-1:0]     out_src_q, out_src_d;

  logic                 rr_found;
  logic [SRC_W-1:0]     rr_idx;
  int                   rr_dist;
  int                   rr_best;

  // Round-robin pick: the valid source closest after last_grant (wrapping) wins.
  always_comb begin
    rr_found = |src_valid_i;
    rr_idx   = '0;
    rr_dist  = 0;
    rr_best  = NUM_SRC;
    for (int j = 0; j < NUM_SRC; j++) begin
      rr_dist = (j + NUM_SRC - 1 - int'(last_grant_q)) % NUM_SRC;
      if (src_valid_i[j] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        rr_idx  = SRC_W'(j);
      end
    end
  end

  // Next-state and strobe logic; FIFO strobes are combinational so a bit is written the cycle it arrives.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    bit_cnt_d    = bit_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    out_word_d   = out_word_q;
    out_src_d    = out_src_q;
    src_ready_o  = '0;
    fifo_enque_o = 1'b0;
    fifo_deque_o = 1'b0;
    fifo_data_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i && rr_found) begin
          grant_d     = rr_idx;
          bit_cnt_d   = '0;
          stall_cnt_d = '0;
          state_d     = FILL;
        end
      end

      FILL: begin
        src_ready_o[grant_q] = 1'b1;
        if (src_valid_i[grant_q]) begin
          fifo_enque_o = 1'b1;
          fifo_data_o  = src_bit_i[grant_q];
          bit_cnt_d    = bit_cnt_q + 1'b1;
          stall_cnt_d  = '0;
          if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
            state_d = DRAIN;
          end
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
          if (stall_cnt_q == STALL_W'(STALL_MAX - 1)) begin
            if (drop_cnt_q != 8'hFF) begin
              drop_cnt_d = drop_cnt_q + 8'd1;
            end
            last_grant_d = grant_q;
            state_d      = (bit_cnt_q != '0) ? FLUSH : IDLE;
          end
        end
      end

      DRAIN: begin
        fifo_deque_o = 1'b1;
        out_word_d   = fifo_vector_i;
        out_src_d    = grant_q;
        last_grant_d = grant_q;
        state_d      = HOLD;
      end

      HOLD: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end

      FLUSH: begin
        fifo_deque_o = 1'b1;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset leaves last_grant at the top index so source 0 is served first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(NUM_SRC - 1);
      bit_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      out_word_q   <= '0;
      out_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      bit_cnt_q    <= bit_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      out_word_q   <= out_word_d;
      out_src_q    <= out_src_d;
    end
  end

  assign out_valid_o = (state_q == HOLD);
  assign out_word_o  = out_word_q;
  assign out_src_o   = out_src_q;
  assign drop_cnt_o  = drop_cnt_q;

  // The FIFO must report full exactly while we drain it; the controller itself trusts bit_cnt.
  a_full_only_in_drain: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_full_i == (state_q == DRAIN));

  a_no_enque_and_deque: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_enque_o && fifo_deque_o));

endmodule

// File: doc/adc_rng_ctrl.md
ADC_RNG_CTRL -- requirements
Module: adc_rng_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 4: number of ADC bit-source requesters.
REQ-002 Parameter WORD_BITS, default ADC_FIF0_DEPTH (10, from params): bits per assembled word.
REQ-003 Parameter STALL_MAX, default 16: idle cycles tolerated from a granted source before abort.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 enable  input  1  permits new grants when high.
REQ-007 src_valid  input  NUM_SRC  per-source bit-valid.
REQ-008 src_bit  input  NUM_SRC  per-source random bit.
REQ-009 src_ready  output  NUM_SRC  one-hot; bit accepted from the granted source.
REQ-010 fifo_enque  output  1  write strobe to shared bit FIFO.
REQ-011 fifo_deque  output  1  read/clear strobe to shared bit FIFO.
REQ-012 fifo_data  output  1  bit written to FIFO.
REQ-013 fifo_vector  input  WORD_BITS  FIFO word, valid combinationally during fifo_deque.
REQ-014 fifo_full  input  1  FIFO holds WORD_BITS bits.
REQ-015 out_valid  output  1  out_word/out_src valid.
REQ-016 out_ready  input  1  consumer accepts word.
REQ-017 out_word  output  WORD_BITS  assembled random word.
REQ-018 out_src  output  clog2(NUM_SRC)  index of source that produced out_word.
REQ-019 drop_cnt  output  8  count of aborted words, saturating at 255.

Function
REQ-020 States SHALL be IDLE, FILL, DRAIN, HOLD, FLUSH; one word comes entirely from one source.
REQ-021 IDLE: if enable=1 and any src_valid=1, grant the first valid source searching round-robin from last_grant+1 (mod NUM_SRC), clear bit_cnt and stall_cnt, go FILL next cycle.
REQ-022 FILL: src_ready = one-hot(grant); each cycle src_valid[grant]=1 -> fifo_enque=1, fifo_data=src_bit[grant], bit_cnt+1, stall_cnt cleared, same cycle (zero latency).
REQ-023 FILL: src_valid[grant]=0 -> stall_cnt+1, no enque; other sources' bits ignored, their src_ready=0.
REQ-024 FILL -> DRAIN on the cycle after the enque that makes bit_cnt=WORD_BITS; no enque SHALL occur with bit_cnt=WORD_BITS.
REQ-025 DRAIN (one cycle): fifo_deque=1, fifo_enque=0, register out_word<=fifo_vector, out_src<=grant, last_grant<=grant, go HOLD.
REQ-026 HOLD: out_valid=1 registered; out_word/out_src stable until out_ready=1; handshake -> IDLE next cycle, out_valid=0.
REQ-027 Latency: last-bit enque at cycle N -> out_valid=1 at cycle N+2.
REQ-028 FILL with stall_cnt reaching STALL_MAX -> FLUSH if bit_cnt>0 else IDLE directly; drop_cnt+1 either way; last_grant<=grant.
REQ-029 FLUSH (one cycle): fifo_deque=1, out_valid stays 0, discard vector, go IDLE.
REQ-030 fifo_enque and fifo_deque SHALL never be asserted in the same cycle.
REQ-031 enable=0 blocks only the IDLE grant; FILL/DRAIN/HOLD/FLUSH complete normally.
REQ-032 fifo_full=1 while not in DRAIN, or fifo_full=0 in DRAIN, is a protocol error: controller SHALL still follow bit_cnt (fifo_full is informational, asserted for verification).
REQ-033 drop_cnt at 255 SHALL hold at 255.

Reset
REQ-034 rst=0 asynchronously forces IDLE, last_grant=NUM_SRC-1 (source 0 first), bit_cnt=0, stall_cnt=0, drop_cnt=0.
REQ-035 During reset all outputs 0: src_ready, fifo_enque, fifo_deque, fifo_data, out_valid, out_word, out_src, drop_cnt.
REQ-036 Reset mid-FILL abandons the partial word without deque; FIFO is reset by its own reset in the same domain.

Verification
REQ-037 Source 0 valid continuously, bits 1010110011, out_ready=1 -> 10 enques, deque 1 cycle later, out_word=10'b1100110101 (bit0 first written), out_src=0, out_valid 2 cycles after last enque.
REQ-038 All 4 sources valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0; no interleaving of bits between sources.
REQ-039 Source 2 sends 4 bits then src_valid=0 for 16 cycles -> FLUSH deque, no out_valid, drop_cnt=1, next grant source 3 if valid.
REQ-040 out_ready=0 for 20 cycles in HOLD -> out_valid/out_word stable, no src_ready, no enque; release -> one transfer, IDLE.
REQ-041 Assert rst=0 asynchronously after 5 bits of a word -> all outputs 0 immediately; after release first grant is source 0.
REQ-042 enable=0 while in FILL with 7 bits -> word completes and is delivered; no new grant until enable=1.
